mux_2x1_arbiter: RTL and testbench
==================================

MUX_2X1_ARBITER -- requirements
Module: mux_2x1_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of each requester path.
REQ-002 SHALL have parameter MAX_HOLD, default 4: maximum consecutive grant cycles while the other side waits (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_a  input  1  requester A asks for the shared path.
REQ-006 SHALL have port req_b  input  1  requester B asks for the shared path.
REQ-007 SHALL have port a  input  WIDTH  requester A data.
REQ-008 SHALL have port b  input  WIDTH  requester B data.
REQ-009 SHALL have port gnt_a  output  1  A owns the path (registered).
REQ-010 SHALL have port gnt_b  output  1  B owns the path (registered).
REQ-011 SHALL have port sel  output  1  mux select: 0 = a, 1 = b (registered).
REQ-012 SHALL have port y  output  WIDTH  registered mux output.
REQ-013 SHALL have port y_valid  output  1  y carries granted data.

Function
REQ-014 SHALL implement FSM states IDLE, GNT_A, GNT_B; gnt_a=1 only in GNT_A, gnt_b=1 only in GNT_B, sel=1 only in GNT_B.
REQ-015 SHALL grant within 1 cycle: req seen at edge N -> gnt high after edge N.
REQ-016 IDLE: only req_a -> GNT_A; only req_b -> GNT_B; both -> side not in last_served; neither -> IDLE.
REQ-017 GNT_A: req_a low -> GNT_B if req_b else IDLE; req_a high and req_b low -> stay; both high -> stay until hold_cnt = MAX_HOLD-1, then GNT_B.
REQ-018 GNT_B: symmetric to REQ-017 with roles swapped.
REQ-019 SHALL count hold_cnt (8 bit) up each cycle in a grant state, clear on any state change, saturate at MAX_HOLD-1 when no contention.
REQ-020 SHALL update last_served to the granted side on every entry into GNT_A or GNT_B.
REQ-021 SHALL register y <= selected data and y_valid <= gnt_a|gnt_b each cycle: 1-cycle latency from grant to data.
REQ-022 SHALL never assert gnt_a and gnt_b together; switches A->B go directly without an IDLE cycle.
REQ-023 When y_valid=0, y SHALL hold its previous value.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, gnt_a=0, gnt_b=0, sel=0, y=0, y_valid=0, hold_cnt=0, last_served=B (so A wins first tie).
REQ-025 Reset asserted mid-grant SHALL drop grants without waiting for a clock; first grant after release follows REQ-016.

Structure
REQ-026 State encodings (IDLE=2'b00, GNT_A=2'b01, GNT_B=2'b10) SHALL live in shared package arb_pkg.
REQ-027 SHALL instantiate existing mux_2x1 once per data bit via generate, with sel from the FSM; no other sub-modules.

Verification
REQ-028 Reset: rst_n=0 with req_a=req_b=1 -> all outputs 0; release -> gnt_a=1 next edge, y=a one edge later.
REQ-029 Single requester: req_b=1 only, b=8'hA5 -> gnt_b=1, sel=1, then y=8'hA5, y_valid=1; req_b=0 -> IDLE, y_valid=0 next edge.
REQ-030 Tie fairness: both request from IDLE twice (separated by IDLE) -> first gnt_a, second gnt_b.
REQ-031 Preemption: MAX_HOLD=4, req_a held, req_b raised -> gnt_a exactly 4 cycles, then gnt_b, never both high.
REQ-032 Handover: in GNT_A, req_a drops while req_b=1 -> gnt_b next edge, no IDLE cycle, y switches to b one edge after.
REQ-033 Async reset mid-grant: rst_n low between edges in GNT_B -> gnt_b, sel, y_valid 0 before next edge.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the two-requester arbiter.
// Holds FSM state encodings and the side record used for tie-breaking.
package arb_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_e;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

endpackage

// File: rtl/mux_2x1.sv
// Single-bit 2:1 multiplexer.
// Ports: a_i/b_i data in, sel_i (0=a, 1=b), y_o selected bit.
module mux_2x1 (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux_2x1_arbiter.sv
// Fair two-requester arbiter driving a registered shared 2:1 data path.
// Ports: clk, rst_n, req_a/req_b, a/b data; gnt_a/gnt_b, sel, y, y_valid.
module mux_2x1_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  import arb_pkg::*;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  side_e            last_q, last_d;
  logic             hold_max;

  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] y_q;
  logic             y_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= SIDE_B;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign hold_max = (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_a && req_b)
          state_d = (last_q == SIDE_B) ? GNT_A : GNT_B;
        else if (req_a)
          state_d = GNT_A;
        else if (req_b)
          state_d = GNT_B;
      end
      GNT_A: begin
        if (!req_a)
          state_d = req_b ? GNT_B : IDLE;
        else if (req_b && hold_max)
          state_d = GNT_B;
      end
      GNT_B: begin
        if (!req_b)
          state_d = req_a ? GNT_A : IDLE;
        else if (req_a && hold_max)
          state_d = GNT_A;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter runs in any grant state; it saturates so a
  // lone owner is preempted at once when contention starts.
  always_comb begin
    hold_d = hold_q;
    last_d = last_q;
    if (state_d != state_q || state_q == IDLE)
      hold_d = '0;
    else if (!hold_max)
      hold_d = hold_q + 1'b1;
    if (state_d != state_q) begin
      if (state_d == GNT_A)
        last_d = SIDE_A;
      else if (state_d == GNT_B)
        last_d = SIDE_B;
    end
  end

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    sel   = 1'b0;
    unique case (1'b1)
      (state_q == GNT_A): gnt_a = 1'b1;
      (state_q == GNT_B): begin
        gnt_b = 1'b1;
        sel   = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux_2x1 u_mux (
      .a_i  (a[i]),
      .b_i  (b[i]),
      .sel_i(sel),
      .y_o  (mux_y[i])
    );
  end

  // y only loads while a grant is live, so it holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= gnt_a | gnt_b;
      if (gnt_a | gnt_b)
        y_q <= mux_y;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Scoreboard bench for mux_2x1_arbiter (WIDTH=8, MAX_HOLD=4).
// Directed per-cycle vectors push expectations; a monitor pops them.
module tb_mux_2x1_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req_a, req_b;
  logic [7:0] a, b;
  logic       gnt_a, gnt_b, sel, y_valid;
  logic [7:0] y;

  typedef struct {
    int         id;
    logic       ga;
    logic       gb;
    logic       yv;
    logic [7:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk;
  int   n_err;
  int   vec_id;

  mux_2x1_arbiter #(
    .WIDTH   (8),
    .MAX_HOLD(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_a  (req_a),
    .req_b  (req_b),
    .a      (a),
    .b      (b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .sel    (sel),
    .y      (y),
    .y_valid(y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and record what must be
  // visible just after the coming rising edge.
  task automatic cyc(
    input logic       rn,
    input logic       ra,
    input logic       rb,
    input logic [7:0] av,
    input logic [7:0] bv,
    input logic       ega,
    input logic       egb,
    input logic       eyv,
    input logic [7:0] ey
  );
    exp_t e;
    @(negedge clk);
    rst_n = rn;
    req_a = ra;
    req_b = rb;
    a     = av;
    b     = bv;
    e.id  = vec_id;
    e.ga  = ega;
    e.gb  = egb;
    e.yv  = eyv;
    e.y   = ey;
    exp_q.push_back(e);
    vec_id++;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (gnt_a !== e.ga || gnt_b !== e.gb ||
          sel !== e.gb || y_valid !== e.yv ||
          y !== e.y) begin
        n_err++;
        $display("FAIL vec%0d: got ga=%b gb=%b sel=%b yv=%b y=%h, want ga=%b gb=%b sel=%b yv=%b y=%h",
                 e.id, gnt_a, gnt_b, sel, y_valid, y,
                 e.ga, e.gb, e.gb, e.yv, e.y);
      end
      n_chk++;
      if (gnt_a === 1'b1 && gnt_b === 1'b1) begin
        n_err++;
        $display("FAIL both_gnt vec%0d: ga=%b gb=%b, want not both",
                 e.id, gnt_a, gnt_b);
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_err  = 0;
    vec_id = 0;
    rst_n  = 1'b0;
    req_a  = 1'b1;
    req_b  = 1'b1;
    a      = 8'h11;
    b      = 8'h22;

    // Reset held with both requesting, then release.
    cyc(0, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00);
    cyc(0, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00);
    cyc(1, 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'h00);
    cyc(1, 1, 1, 8'h11, 8'h22, 1, 0, 1, 8'h11);
    cyc(1, 0, 0, 8'h11, 8'h22, 0, 0, 1, 8'h11);
    cyc(1, 0, 0, 8'h11, 8'h22, 0, 0, 0, 8'h11);

    // Single requester B.
    cyc(1, 0, 1, 8'h11, 8'hA5, 0, 1, 0, 8'h11);
    cyc(1, 0, 1, 8'h11, 8'hA5, 0, 1, 1, 8'hA5);
    cyc(1, 0, 0, 8'h11, 8'hA5, 0, 0, 1, 8'hA5);
    cyc(1, 0, 0, 8'h11, 8'hA5, 0, 0, 0, 8'hA5);

    // Tie from IDLE twice: A then B.
    cyc(1, 1, 1, 8'h3C, 8'hC3, 1, 0, 0, 8'hA5);
    cyc(1, 0, 0, 8'h3C, 8'hC3, 0, 0, 1, 8'h3C);
    cyc(1, 0, 0, 8'h3C, 8'hC3, 0, 0, 0, 8'h3C);
    cyc(1, 1, 1, 8'h3C, 8'hC3, 0, 1, 0, 8'h3C);
    cyc(1, 0, 0, 8'h3C, 8'hC3, 0, 0, 1, 8'hC3);
    cyc(1, 0, 0, 8'h3C, 8'hC3, 0, 0, 0, 8'hC3);

    // Contention: each side holds exactly 4 cycles.
    cyc(1, 1, 1, 8'h01, 8'h02, 1, 0, 0, 8'hC3);
    cyc(1, 1, 1, 8'h01, 8'h02, 1, 0, 1, 8'h01);
    cyc(1, 1, 1, 8'h01, 8'h02, 1, 0, 1, 8'h01);
    cyc(1, 1, 1, 8'h01, 8'h02, 1, 0, 1, 8'h01);
    cyc(1, 1, 1, 8'h01, 8'h02, 0, 1, 1, 8'h01);
    cyc(1, 1, 1, 8'h01, 8'h02, 0, 1, 1, 8'h02);
    cyc(1, 1, 1, 8'h01, 8'h02, 0, 1, 1, 8'h02);
    cyc(1, 1, 1, 8'h01, 8'h02, 0, 1, 1, 8'h02);
    cyc(1, 1, 1, 8'h01, 8'h02, 1, 0, 1, 8'h02);

    // Handover A->B without an IDLE cycle.
    cyc(1, 0, 1, 8'h01, 8'h02, 0, 1, 1, 8'h01);
    cyc(1, 0, 1, 8'h01, 8'h02, 0, 1, 1, 8'h02);

    // Lone B saturates its count; A is then served at once.
    cyc(1, 0, 1, 8'h01, 8'h02, 0, 1, 1, 8'h02);
    cyc(1, 0, 1, 8'h01, 8'h02, 0, 1, 1, 8'h02);
    cyc(1, 0, 1, 8'h01, 8'h02, 0, 1, 1, 8'h02);
    cyc(1, 1, 1, 8'h01, 8'h02, 1, 0, 1, 8'h02);
    cyc(1, 0, 1, 8'h01, 8'h02, 0, 1, 1, 8'h01);
    cyc(1, 0, 1, 8'h01, 8'h02, 0, 1, 1, 8'h02);

    // Asynchronous reset while B owns the path.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (gnt_b !== 1'b0 || sel !== 1'b0 ||
        y_valid !== 1'b0 || gnt_a !== 1'b0 ||
        y !== 8'h00) begin
      n_err++;
      $display("FAIL async_rst: got ga=%b gb=%b sel=%b yv=%b y=%h, want all 0",
               gnt_a, gnt_b, sel, y_valid, y);
    end
    cyc(0, 0, 1, 8'h77, 8'h02, 0, 0, 0, 8'h00);
    cyc(1, 1, 1, 8'h77, 8'h02, 1, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h77, 8'h02, 0, 0, 1, 8'h77);
    cyc(1, 0, 0, 8'h77, 8'h02, 0, 0, 0, 8'h77);

    @(posedge clk);
    #3;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0",
               exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
